mlp_layer_sequencer: RTL and testbench

- Control-path sequencer for one fully-connected MLP layer inside the matrix-multiplication AXI-Stream coprocessor.
- Computes out[r] = sum over c of A[r][c]*B[c]. It walks the weight RAM (A, row-major) and the input RAM (B), and drives a single shared MAC unit's clear/enable strobes.
- Issues result-RAM writes, one per row; the AXI-Stream output logic drains the result RAM afterwards.
- Started by the stream-input FSM once all input words are stored; reports done back to it.

---
 rtl/mlp_layer_sequencer_pkg.sv | 35 +++
 rtl/mlp_layer_sequencer_if.sv | 15 +
 rtl/mlp_layer_sequencer_pipe.sv | 26 ++
 rtl/mlp_layer_sequencer.sv | 153 +++++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mlp_layer_sequencer_pkg.sv
// Shared types and limits for the MLP layer sequencer.
// The optional cycle counter is enabled with MLP_SEQ_CYCLE_CNT_EN.
package mlp_seq_pkg;

    localparam int ROW_W        = 8;
    localparam int COL_W        = 10;
    localparam int ADDR_W       = 16;
    localparam int MAX_ROWS_DEF = 128;
    localparam int MAX_COLS_DEF = 512;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    typedef struct packed {
        logic             valid;
        logic             first;
        logic             last;
        logic [ROW_W-1:0] row;
    } pipe_ent_t;

    function automatic pipe_ent_t make_ent(input logic first, input logic last,
                                           input logic [ROW_W-1:0] row);
        pipe_ent_t e;
        e.valid = 1'b1;
        e.first = first;
        e.last  = last;
        e.row   = row;
        return e;
    endfunction

endpackage

// File: rtl/mlp_layer_sequencer_if.sv
// RAM read / MAC strobe / result write bus driven by the MLP layer sequencer.
interface mlp_layer_sequencer_if;

    logic                             mem_rd;
    logic [mlp_seq_pkg::ADDR_W-1:0]   a_addr;
    logic [mlp_seq_pkg::COL_W-1:0]    b_addr;
    logic                             mac_clr;
    logic                             mac_en;
    logic                             res_we;
    logic [mlp_seq_pkg::ROW_W-1:0]    res_addr;

    modport master (output mem_rd, a_addr, b_addr, mac_clr, mac_en, res_we, res_addr);
    modport slave  (input  mem_rd, a_addr, b_addr, mac_clr, mac_en, res_we, res_addr);

endinterface

// File: rtl/mlp_layer_sequencer_pipe.sv
// Fixed-depth shift register carrying issue flags alongside the RAM/MAC latency.
module mlp_seq_pipe
    import mlp_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  pipe_ent_t din,
    output pipe_ent_t dout
);

    pipe_ent_t stg [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
        end else begin
            stg[0] <= din;
            for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
    end

    assign dout = stg[DEPTH-1];

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Control sequencer for one fully-connected layer: walks A/B RAMs, strobes the MAC, writes results.
// Optional 32-bit busy-cycle counter output is enabled by defining MLP_SEQ_CYCLE_CNT_EN.
//
// state   | meaning
// IDLE    | waiting for start
// ISSUE   | one A/B read per cycle, row-major
// DRAIN   | waiting for the final result write to leave the pipeline
// DONE    | one-cycle done (and err) pulse
module mlp_layer_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int MAX_ROWS = MAX_ROWS_DEF,
    parameter int MAX_COLS = MAX_COLS_DEF,
    parameter int RD_LAT   = 1,
    parameter int MAC_LAT  = 1
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 start,
    input  logic [ROW_W-1:0]     n_rows,
    input  logic [COL_W-1:0]     n_cols,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    mlp_layer_sequencer_if.master mem
`ifdef MLP_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]          cycle_cnt
`endif
);

    seq_state_t        state;
    logic [ROW_W-1:0]  rows_m1;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  cols_m1;
    logic [COL_W-1:0]  col_q;
    logic [ADDR_W-1:0] a_q;
    logic              rd_q;
    pipe_ent_t         iss;
    pipe_ent_t         mac_ent;
    pipe_ent_t         res_ent;
    logic              size_ok;
    logic              final_we;

    assign size_ok = (n_rows != '0) && ({1'b0, n_rows} <= (ROW_W+1)'(MAX_ROWS)) &&
                     (n_cols != '0) && ({1'b0, n_cols} <= (COL_W+1)'(MAX_COLS));

    assign final_we = res_ent.valid && res_ent.last && (res_ent.row == rows_m1);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rd_q    <= 1'b0;
            a_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rows_m1 <= '0;
            cols_m1 <= '0;
            iss     <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (size_ok) begin
                            rows_m1 <= n_rows - ROW_W'(1);
                            cols_m1 <= n_cols - COL_W'(1);
                            row_q   <= '0;
                            col_q   <= '0;
                            a_q     <= '0;
                            rd_q    <= 1'b1;
                            iss     <= make_ent(1'b1, n_cols == COL_W'(1), '0);
                            state   <= S_ISSUE;
                        end else begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    // row_q/col_q always name the read currently on the bus
                    if (row_q == rows_m1 && col_q == cols_m1) begin
                        rd_q  <= 1'b0;
                        iss   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        a_q <= a_q + ADDR_W'(1);
                        if (col_q == cols_m1) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_W'(1);
                            iss   <= make_ent(1'b1, cols_m1 == '0, row_q + ROW_W'(1));
                        end else begin
                            col_q <= col_q + COL_W'(1);
                            iss   <= make_ent(1'b0, (col_q + COL_W'(1)) == cols_m1, row_q);
                        end
                    end
                end
                S_DRAIN: begin
                    if (final_we) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    mlp_seq_pipe #(.DEPTH(RD_LAT)) u_rd_pipe (
        .clk  (ACLK),
        .rst  (ARESET),
        .din  (iss),
        .dout (mac_ent)
    );

    mlp_seq_pipe #(.DEPTH(MAC_LAT)) u_mac_pipe (
        .clk  (ACLK),
        .rst  (ARESET),
        .din  (mac_ent),
        .dout (res_ent)
    );

    assign mem.mem_rd   = rd_q;
    assign mem.a_addr   = a_q;
    assign mem.b_addr   = col_q;
    assign mem.mac_en   = mac_ent.valid;
    assign mem.mac_clr  = mac_ent.valid & mac_ent.first;
    assign mem.res_we   = res_ent.valid & res_ent.last;
    assign mem.res_addr = (res_ent.valid & res_ent.last) ? res_ent.row : '0;

`ifdef MLP_SEQ_CYCLE_CNT_EN
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cycle_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            cycle_cnt <= '0;
        end else if (busy && cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Randomized bench for mlp_layer_sequencer: two instances (latencies 1/1 and 2/2) vs. an arithmetic trace model.
module tb_mlp_layer_sequencer;

    logic       ACLK = 1'b0;
    logic       ARESET = 1'b1;
    logic       start = 1'b0;
    logic [7:0] n_rows = '0;
    logic [9:0] n_cols = '0;
    logic       busy_a, done_a, err_a;
    logic       busy_b, done_b, err_b;
    int         checks = 0;
    int         failures = 0;

    mlp_layer_sequencer_if mem_a ();
    mlp_layer_sequencer_if mem_b ();

`ifdef MLP_SEQ_CYCLE_CNT_EN
    logic [31:0] cc_a, cc_b;
`endif

    always #5 ACLK = ~ACLK;

    mlp_layer_sequencer #(.RD_LAT(1), .MAC_LAT(1)) dut_a (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .n_rows(n_rows), .n_cols(n_cols),
        .busy(busy_a), .done(done_a), .err(err_a), .mem(mem_a)
`ifdef MLP_SEQ_CYCLE_CNT_EN
        , .cycle_cnt(cc_a)
`endif
    );

    mlp_layer_sequencer #(.RD_LAT(2), .MAC_LAT(2)) dut_b (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .n_rows(n_rows), .n_cols(n_cols),
        .busy(busy_b), .done(done_b), .err(err_b), .mem(mem_b)
`ifdef MLP_SEQ_CYCLE_CNT_EN
        , .cycle_cnt(cc_b)
`endif
    );

    // {busy, done, err, mem_rd, mac_en, mac_clr, res_we, a_addr, b_addr, res_addr}
    logic [40:0] obs_a, obs_b;
    assign obs_a = {busy_a, done_a, err_a, mem_a.mem_rd, mem_a.mac_en, mem_a.mac_clr,
                    mem_a.res_we, mem_a.a_addr, mem_a.b_addr, mem_a.res_addr};
    assign obs_b = {busy_b, done_b, err_b, mem_b.mem_rd, mem_b.mac_en, mem_b.mac_clr,
                    mem_b.res_we, mem_b.a_addr, mem_b.b_addr, mem_b.res_addr};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected bus trace for cycle t after the start edge, from the layer's arithmetic alone.
    function automatic void model(input int t, input int R, input int C, input int rd,
                                  input int mc, input int rst_t,
                                  output logic [40:0] e, output logic [40:0] m);
        int  n, p, k;
        bit  rdv, wev;
        e   = '0;
        m   = '1;
        rdv = 1'b0;
        wev = 1'b0;
        if (rst_t > 0 && t > rst_t) return;
        if (!(R >= 1 && R <= 128 && C >= 1 && C <= 512)) begin
            if (t == 1) e[40:38] = 3'b111;
        end else begin
            n = R * C;
            p = rd + mc;
            e[40] = (t >= 1 && t <= n + p + 1);
            e[39] = (t == n + p + 1);
            if (t >= 1 && t <= n) begin
                rdv = 1'b1;
                e[37] = 1'b1;
                e[33:18] = 16'(t - 1);
                e[17:8]  = 10'((t - 1) % C);
            end
            k = t - rd - 1;
            if (k >= 0 && k < n) begin
                e[36] = 1'b1;
                e[35] = (k % C == 0);
            end
            k = t - p - 1;
            if (k >= 0 && k < n && (k % C) == C - 1) begin
                wev = 1'b1;
                e[34] = 1'b1;
                e[7:0] = 8'(k / C);
            end
        end
        if (!rdv) m[33:8] = '0;
        if (!wev) m[7:0]  = '0;
    endfunction

    task automatic run(input string name, input int R, input int C, input int rep_t, input int rst_t);
        logic [40:0] ea, ma, eb, mb;
        int  n, tmax, f0, nrd, nwe, done_t, last_a;
        bit  legal;
        legal  = (R >= 1 && R <= 128 && C >= 1 && C <= 512);
        n      = legal ? R * C : 0;
        tmax   = legal ? n + 8 : 4;
        f0     = failures;
        nrd    = 0;
        nwe    = 0;
        done_t = 0;
        last_a = -1;
        @(negedge ACLK);
        start  = 1'b1;
        n_rows = 8'(R);
        n_cols = 10'(C);
        @(posedge ACLK);
        for (int t = 1; t <= tmax; t++) begin
            @(negedge ACLK);
            if (t == 1) start = 1'b0;
            model(t, R, C, 1, 1, rst_t, ea, ma);
            model(t, R, C, 2, 2, rst_t, eb, mb);
            if (failures - f0 < 12) begin
                check_eq($sformatf("%s A t=%0d", name, t), 64'(obs_a & ma), 64'(ea));
                check_eq($sformatf("%s B t=%0d", name, t), 64'(obs_b & mb), 64'(eb));
            end
            if (mem_a.mem_rd) begin
                nrd++;
                last_a = int'(mem_a.a_addr);
            end
            if (mem_a.res_we) nwe++;
            if (done_a && done_t == 0) done_t = t;
`ifdef MLP_SEQ_CYCLE_CNT_EN
            if (t == 1) begin
                check_eq({name, " cc_a clear"}, 64'(cc_a), 64'd0);
                check_eq({name, " cc_b clear"}, 64'(cc_b), 64'd0);
            end
`endif
            if (t == rep_t) begin
                start  = 1'b1;
                n_rows = 8'd3;
                n_cols = 10'd4;
            end
            if (t == rep_t + 1) start = 1'b0;
            if (t == rst_t) ARESET = 1'b1;
            if (t == rst_t + 1) ARESET = 1'b0;
        end
        if (rst_t > 0) begin
            check_eq({name, " no done"}, 64'(done_t), 64'd0);
        end else begin
            check_eq({name, " rd count"}, 64'(nrd), 64'(n));
            check_eq({name, " we count"}, 64'(nwe), 64'(legal ? R : 0));
            check_eq({name, " done cyc"}, 64'(done_t), 64'(legal ? n + 3 : 1));
            if (legal) check_eq({name, " last a_addr"}, 64'(last_a), 64'(n - 1));
        end
`ifdef MLP_SEQ_CYCLE_CNT_EN
        check_eq({name, " cc_a hold"}, 64'(cc_a), 64'(rst_t > 0 ? 0 : (legal ? n + 3 : 1)));
        check_eq({name, " cc_b hold"}, 64'(cc_b), 64'(rst_t > 0 ? 0 : (legal ? n + 5 : 1)));
`endif
    endtask

    initial begin
        int r, c;
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_eq("reset A", 64'(obs_a), 64'd0);
        check_eq("reset B", 64'(obs_b), 64'd0);
`ifdef MLP_SEQ_CYCLE_CNT_EN
        check_eq("reset cc_a", 64'(cc_a), 64'd0);
`endif
        ARESET = 1'b0;

        run("basic_2x3", 2, 3, 0, 0);
        run("illegal_r0", 0, 3, 0, 0);
        run("illegal_c600", 2, 600, 0, 0);
        run("cols1_4x1", 4, 1, 0, 0);
        run("repulse", 2, 3, 3, 0);
        run("reset_mid", 2, 3, 0, 4);
        run("after_rst", 2, 3, 0, 0);
        for (int i = 0; i < 20; i++) begin
            r = int'($urandom_range(1, 6));
            c = int'($urandom_range(1, 9));
            run($sformatf("rand%0d_%0dx%0d", i, r, c), r, c, 0, 0);
        end
        run("rand_bad_r", int'($urandom_range(129, 255)), int'($urandom_range(1, 9)), 0, 0);
        run("rand_bad_c", int'($urandom_range(1, 6)), int'($urandom_range(513, 1023)), 0, 0);
        run("illegal_c0", 3, 0, 0, 0);
        run("edge_1x1", 1, 1, 0, 0);
        run("full_128x467", 128, 467, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
